core_debug_responder: RTL
=========================

CORE_DEBUG_RESPONDER -- requirements
Module: core_debug_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the 64 KiB window base; only wbAddress[31:16] is compared.
REQ-002 SHALL have parameter CSR_TIMEOUT, default 15, meaning the maximum cycles to wait for csrReadValid.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wbEnable / wbWriteEnable  input  1 each  request strobe / write qualifier.
REQ-006 wbAddress  input  32  byte address.
REQ-007 wbByteSelect  input  4  byte lanes.
REQ-008 wbDataWrite  input  32  write data.
REQ-009 wbDataRead  output  32  read data, valid only in the completion cycle.
REQ-010 wbBusy  output  1  high while a selected request is not yet complete.
REQ-011 coreHalt  output  1  1 = core halted.
REQ-012 coreStep / coreJump  output  1 each  single-cycle command pulses.
REQ-013 coreJumpAddress  output  32  jump target, held stable from the coreJump pulse until the next jump.
REQ-014 coreProgramCounter / coreInstruction  input  32 each  live PC and current instruction.
REQ-015 coreStepDone  input  1  pulse when the stepped instruction retires.
REQ-016 csrReadEnable  output  1  CSR read request.
REQ-017 csrAddress  output  12  CSR number.
REQ-018 csrReadData  input  32  CSR data.
REQ-019 csrReadValid  input  1  CSR data valid.

Function
REQ-020 Select SHALL be wbEnable && wbAddress[31:16]==BASE_ADDR[31:16]; unselected requests SHALL keep wbBusy=0 and cause no state change.
REQ-021 Register map (offset = wbAddress[15:0]) SHALL be:
- 0x0000 CONFIG, R/W, bit0 run, other bits read 0.
- 0x0010 PC, RO.
- 0x0014 JUMP, WO.
- 0x0018 STEP, WO.
- 0x001C INSTR, RO.
- 0x4000–0x7FFC CSR window, RO, CSR number = offset[13:2].
REQ-022 FSM states SHALL be IDLE, CSR_WAIT, STEP_WAIT, DONE; only DONE drives wbBusy=0 while selected.
REQ-023 Plain register access SHALL take the path IDLE -> DONE -> IDLE, completing in the second cycle of the request with wbBusy=0 and wbDataRead valid.
REQ-024 The master SHALL drop wbEnable after completion; if it does not, the request held in IDLE SHALL be treated as a new transaction.
REQ-025 A CONFIG write SHALL update run only when wbByteSelect[0]=1, and coreHalt SHALL equal ~run from the cycle after DONE.
REQ-026 A JUMP write SHALL require wbByteSelect=4'hF; on acceptance it SHALL latch coreJumpAddress and pulse coreJump once, in the cycle the FSM enters DONE.
REQ-027 A STEP write while coreHalt=1 SHALL pulse coreStep once on entering STEP_WAIT, then wait for coreStepDone -> DONE; written data SHALL be ignored.
REQ-028 A STEP write while coreHalt=0 SHALL complete as a plain access with no pulse.
REQ-029 A CSR read SHALL assert csrReadEnable with csrAddress held in CSR_WAIT; csrReadValid SHALL latch csrReadData -> DONE.
REQ-030 A CSR read with no csrReadValid after CSR_TIMEOUT cycles SHALL return 32'hFFFF_FFFF.
REQ-031 Writes to the CSR window SHALL be ignored and complete in 2 cycles.
REQ-032 Reads SHALL ignore wbByteSelect; PC and INSTR reads SHALL sample their inputs in the IDLE cycle.
REQ-033 Unmapped offsets SHALL read 0, ignore writes, and complete normally.
REQ-034 A STEP_WAIT lasting 64 cycles without coreStepDone SHALL complete anyway.
REQ-035 coreStepDone or csrReadValid arriving outside its wait state SHALL be ignored.

Reset
REQ-036 rst=0 SHALL asynchronously force the following, all held while rst=0:
- FSM to IDLE.
- run=0, so coreHalt=1.
- coreStep=0, coreJump=0, csrReadEnable=0, wbBusy=0.
- coreJumpAddress=0, wbDataRead=0.
REQ-037 Reset mid-transaction SHALL abort the transaction with no command pulse emitted, and the master SHALL reissue it.

Verification
REQ-038 Post-reset read of 0x3000_0000 -> 32'h0, coreHalt=1, completing in cycle 2.
REQ-039 Write 0x3000_0000=1 with byteSelect 4'h1 -> coreHalt=0, readback 1; the same write with byteSelect 4'h2 -> no change.
REQ-040 With the core halted, write JUMP=0x100 -> single coreJump pulse, coreJumpAddress=0x100; STEP with coreStepDone returned 3 cycles later -> wbBusy high for 4 cycles, exactly 1 coreStep pulse.
REQ-041 Read 0x3000_4000+4*0xC02 with csrReadValid after 2 cycles and data 0x1234 -> wbDataRead=0x1234, csrAddress=0xC02; the same read with no valid -> 0xFFFF_FFFF after 15 cycles.
REQ-042 Request to 0x3001_0000 -> wbBusy stays 0 and no outputs change; STEP while running -> completes in 2 cycles, no pulse.
REQ-043 Assert rst during STEP_WAIT -> wbBusy=0 and coreHalt=1 immediately, FSM in IDLE after release.

Source files
------------

// File: rtl/core_debug_responder.sv
// Wishbone-style debug responder: run/halt control, jump, single-step,
// and a read-only CSR window onto the core, behind a 64 KiB bus window.
module core_debug_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          CSR_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbEnable,
  input  logic        wbWriteEnable,
  input  logic [31:0] wbAddress,
  input  logic [3:0]  wbByteSelect,
  input  logic [31:0] wbDataWrite,
  output logic [31:0] wbDataRead,
  output logic        wbBusy,
  output logic        coreHalt,
  output logic        coreStep,
  output logic        coreJump,
  output logic [31:0] coreJumpAddress,
  input  logic [31:0] coreProgramCounter,
  input  logic [31:0] coreInstruction,
  input  logic        coreStepDone,
  output logic        csrReadEnable,
  output logic [11:0] csrAddress,
  input  logic [31:0] csrReadData,
  input  logic        csrReadValid
);

  typedef enum logic [1:0] {IDLE, CSR_WAIT, STEP_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        run_q, run_d;
  logic        halt_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] jump_addr_q, jump_addr_d;
  logic        jump_q, jump_d;
  logic        step_q, step_d;
  logic        csr_en_q, csr_en_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        sel;
  logic [15:0] offset;
  logic        is_csr;

  assign sel    = wbEnable && (wbAddress[31:16] == BASE_ADDR[31:16]);
  assign offset = wbAddress[15:0];
  assign is_csr = (offset[15:14] == 2'b01);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    rdata_d     = '0;
    jump_addr_d = jump_addr_q;
    jump_d      = 1'b0;
    step_d      = 1'b0;
    csr_en_d    = csr_en_q;
    csr_addr_d  = csr_addr_q;
    cnt_d       = cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel) begin
          state_d = DONE;
          if (wbWriteEnable) begin
            case (offset)
              16'h0000: if (wbByteSelect[0]) run_d = wbDataWrite[0];
              16'h0014: if (wbByteSelect == 4'hF) begin
                jump_addr_d = wbDataWrite;
                jump_d      = 1'b1;
              end
              // Stepping a running core is meaningless; treat it as a plain access.
              16'h0018: if (halt_q) begin
                step_d  = 1'b1;
                state_d = STEP_WAIT;
              end
              default: ;
            endcase
          end else if (is_csr) begin
            state_d    = CSR_WAIT;
            csr_en_d   = 1'b1;
            csr_addr_d = offset[13:2];
          end else begin
            case (offset)
              16'h0000: rdata_d = {31'b0, run_q};
              16'h0010: rdata_d = coreProgramCounter;
              16'h001C: rdata_d = coreInstruction;
              default:  rdata_d = '0;
            endcase
          end
        end
      end
      CSR_WAIT: begin
        if (csrReadValid) begin
          rdata_d  = csrReadData;
          csr_en_d = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == 8'(CSR_TIMEOUT - 1)) begin
          rdata_d  = 32'hFFFF_FFFF;
          csr_en_d = 1'b0;
          state_d  = DONE;
        end
      end
      STEP_WAIT: begin
        if (coreStepDone || cnt_q == 8'd63) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // coreHalt lags run by one cycle so it changes only after the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      halt_q      <= 1'b1;
      rdata_q     <= '0;
      jump_addr_q <= '0;
      jump_q      <= 1'b0;
      step_q      <= 1'b0;
      csr_en_q    <= 1'b0;
      csr_addr_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      halt_q      <= ~run_q;
      rdata_q     <= rdata_d;
      jump_addr_q <= jump_addr_d;
      jump_q      <= jump_d;
      step_q      <= step_d;
      csr_en_q    <= csr_en_d;
      csr_addr_q  <= csr_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wbBusy          = rst && sel && (state_q != DONE);
  assign wbDataRead      = rdata_q;
  assign coreHalt        = halt_q;
  assign coreStep        = step_q;
  assign coreJump        = jump_q;
  assign coreJumpAddress = jump_addr_q;
  assign csrReadEnable   = csr_en_q;
  assign csrAddress      = csr_addr_q;

endmodule
